// File: rtl/arbitro_pkg.sv
// Shared types and constants for the 4x4 round-robin arbiter/router.
package arbitro_pkg;

  localparam int unsigned DATA_W    = 10;
  localparam int unsigned DEST_LSB  = 8;
  localparam int unsigned NUM_PORTS = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StStall  = 2'd2
  } state_e;

  function automatic logic [1:0] get_dest(input logic [DATA_W-1:0] word);
    return word[DEST_LSB +: 2];
  endfunction

endpackage

// File: rtl/arbitro_if.sv
// FIFO-bank side bundle of the arbiter; per-lane signals are indexed by FIFO number.
// Optional per-destination push counters appear when ARBITRO_CNT_EN is defined.
interface arbitro_if;
   import arbitro_pkg::*;

   logic [NUM_PORTS-1:0]             empty;
   logic [NUM_PORTS-1:0][DATA_W-1:0] data_poped;
   logic [NUM_PORTS-1:0]             alm_full;
   logic [NUM_PORTS-1:0]             pop;
   logic [NUM_PORTS-1:0]             push;
   logic [NUM_PORTS-1:0][DATA_W-1:0] data_pushed;
   logic                             idle;
   logic [1:0]                       state;
`ifdef ARBITRO_CNT_EN
   logic [NUM_PORTS-1:0][7:0]        cnt;

   modport master (
      output empty, data_poped, alm_full,
      input  pop, push, data_pushed, idle, state, cnt
   );
   modport slave (
      input  empty, data_poped, alm_full,
      output pop, push, data_pushed, idle, state, cnt
   );
`else
   modport master (
      output empty, data_poped, alm_full,
      input  pop, push, data_pushed, idle, state
   );
   modport slave (
      input  empty, data_poped, alm_full,
      output pop, push, data_pushed, idle, state
   );
`endif

endinterface

// File: rtl/arbitro_rr_sel.sv
// Combinational round-robin selector: first eligible input at or after ptr, modulo 4.
module arbitro_rr_sel
   import arbitro_pkg::*;
(
   input  logic [NUM_PORTS-1:0] eligible,
   input  logic [1:0]           ptr,
   output logic [NUM_PORTS-1:0] grant,
   output logic                 gvalid,
   output logic [1:0]           gidx
);

   logic [2*NUM_PORTS-1:0] dbl;
   logic [NUM_PORTS-1:0]   rot;
   logic [1:0]             off;

   // Rotate so that bit 0 is the pointer target, then pick the lowest set bit.
   always_comb begin
      dbl = {eligible, eligible};
      rot = dbl[ptr +: NUM_PORTS];
      off = 2'd0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (rot[k]) off = 2'(k);
      end
      gvalid = |eligible;
      gidx   = ptr + off;
      grant  = '0;
      if (gvalid) grant[gidx] = 1'b1;
   end

endmodule

// File: rtl/arbitro_rr_4x4.sv
// Four-in/four-out round-robin arbiter moving at most one word per cycle to its destination FIFO.
// Define ARBITRO_CNT_EN to add per-destination 8-bit push counters.
module arbitro_rr_4x4
   import arbitro_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   arbitro_if.slave  bus
);

   logic [1:0]                       ptr_q;
   state_e                           state_q;
   logic [NUM_PORTS-1:0]             push_q;
   logic [NUM_PORTS-1:0][DATA_W-1:0] data_q;
`ifdef ARBITRO_CNT_EN
   logic [NUM_PORTS-1:0][7:0]        cnt_q;
`endif

   logic [NUM_PORTS-1:0] eligible;
   logic [NUM_PORTS-1:0] grant;
   logic                 gvalid;
   logic [1:0]           gidx;
   logic [DATA_W-1:0]    gword;
   logic [1:0]           gdest;

   // A head word whose destination is almost full blocks only its own input.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         eligible[i] = ~bus.empty[i] & ~bus.alm_full[get_dest(bus.data_poped[i])];
      end
   end

   arbitro_rr_sel u_sel (
      .eligible (eligible),
      .ptr      (ptr_q),
      .grant    (grant),
      .gvalid   (gvalid),
      .gidx     (gidx)
   );

   assign gword = bus.data_poped[gidx];
   assign gdest = get_dest(gword);

   assign bus.pop         = rst ? '0 : grant;
   assign bus.push        = push_q;
   assign bus.data_pushed = data_q;
   assign bus.state       = state_q;
   // Unused encoding 3 reads as idle.
   assign bus.idle        = !(state_q inside {StActive, StStall});
`ifdef ARBITRO_CNT_EN
   assign bus.cnt         = cnt_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= 2'd0;
         state_q <= StIdle;
         push_q  <= '0;
         data_q  <= '0;
`ifdef ARBITRO_CNT_EN
         cnt_q   <= '0;
`endif
      end else begin
         push_q <= '0;
         if (gvalid) begin
            push_q[gdest] <= 1'b1;
            data_q[gdest] <= gword;
`ifdef ARBITRO_CNT_EN
            cnt_q[gdest]  <= cnt_q[gdest] + 8'd1;
`endif
            ptr_q         <= gidx + 2'd1;
            state_q       <= StActive;
         end else if (&bus.empty) begin
            state_q <= StIdle;
         end else begin
            state_q <= StStall;
         end
      end
   end

endmodule
